// File: rtl/hdmi_line_pkg.sv
// hdmi_line_pkg: shared widths, RGB332 pixel layout and colour expansion
// for the hdmi_720p line reader.
package hdmi_line_pkg;

   localparam int BANK_BITS = 1;
   localparam int COL_BITS  = 11;

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
   } rgb332_t;

   // Bit replication keeps full-scale codes at 0xFF and zero at 0x00.
   function automatic logic [23:0] expand_rgb332(input logic [7:0] d);
      rgb332_t p;
      p = rgb332_t'(d);
      return {p.r, p.r, p.r[2:1],
              p.g, p.g, p.g[2:1],
              p.b, p.b, p.b, p.b};
   endfunction

endpackage

// File: rtl/hdmi_sync_delay.sv
// hdmi_sync_delay: N-stage register pipe that keeps timing and
// line-status flags aligned with the RAM read and colour stages.
module hdmi_sync_delay
   import hdmi_line_pkg::*;
#(
   parameter int N = 2,
   parameter int W = 4
) (
   input  logic         clock,
   input  logic         nReset,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [W-1:0] stages [N];

   // Shift the flags one stage per pixel clock.
   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         for (int i = 0; i < N; i++) stages[i] <= '0;
      end else begin
         stages[0] <= din;
         for (int i = 1; i < N; i++) stages[i] <= stages[i-1];
      end
   end

   assign dout = stages[N-1];

endmodule

// File: rtl/hdmi_line_reader.sv
// hdmi_line_reader: ping-pong line RAM scan-out with RGB332 expansion.
// Optional build macro LINE_PIXEL_DOUBLE_EN shows each byte for 2 pixels.
module hdmi_line_reader
   import hdmi_line_pkg::*;
#(
   parameter int H_ACTIVE       = 1280,
   parameter int UNDERRUN_CNT_W = 8
) (
   input  logic                      clock,
   input  logic                      nReset,
   input  logic                      activeIn,
   input  logic                      hsyncIn,
   input  logic                      vsyncIn,
   input  logic                      bankFilled,
   input  logic                      bankFilledId,
   output logic [11:0]               ramAddress,
   input  logic [7:0]                ramData,
   output logic [23:0]               rgbOut,
   output logic                      activeOut,
   output logic                      hsyncOut,
   output logic                      vsyncOut,
   output logic                      lineDone,
   output logic                      lineDoneBank,
   output logic [UNDERRUN_CNT_W-1:0] underrunCount
);

   if (H_ACTIVE < 1 || H_ACTIVE > 2048) begin : g_bad_h_active
      $error("H_ACTIVE must be within 1..2048");
   end

   localparam logic [COL_BITS-1:0] COL_MAX = '1;

   logic [BANK_BITS-1:0] readBank;
   logic [COL_BITS-1:0]  column;
   logic [1:0]           ready;
   logic [1:0]           readySet;
   logic [1:0]           readyClr;
   logic                 lineBad;
   logic                 lineBadNext;
   logic                 activePrev;
   logic                 vsyncPrev;
   logic                 lineRise;
   logic                 lineFall;
   logic                 frameRise;
   logic [23:0]          rgbReg;
   logic [3:0]           pipeIn;
   logic [3:0]           pipeOut;

   // Edge detects and ready-bit set/clear requests for this cycle.
   always_comb begin
      lineRise  = activeIn & ~activePrev;
      lineFall  = ~activeIn & activePrev;
      frameRise = vsyncIn & ~vsyncPrev;
      readySet  = '0;
      readyClr  = '0;
      if (bankFilled) readySet[bankFilledId] = 1'b1;
      if (lineFall) readyClr[readBank] = 1'b1;
      lineBadNext = lineBad;
      if (lineRise) lineBadNext = ~ready[readBank];
   end

   // Timing history for edge detection.
   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         activePrev <= 1'b0;
         vsyncPrev  <= 1'b0;
      end else begin
         activePrev <= activeIn;
         vsyncPrev  <= vsyncIn;
      end
   end

   // Column walks the active line and parks at the bank's last byte.
   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         column <= '0;
      end else if (frameRise) begin
         column <= '0;
      end else if (activeIn) begin
         if (column != COL_MAX) column <= column + 1'b1;
      end else begin
         column <= '0;
      end
   end

   // Bank selection: swap on line end, back to bank 0 on frame start.
   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         readBank <= '0;
      end else if (frameRise) begin
         readBank <= '0;
      end else if (lineFall) begin
         readBank <= ~readBank;
      end
   end

   // Ready bits: a fill arriving with the release keeps the bank ready.
   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         ready <= '0;
      end else begin
         ready <= (ready & ~readyClr) | readySet;
      end
   end

   // Underrun flag and saturating count, sampled at line start.
   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         lineBad       <= 1'b0;
         underrunCount <= '0;
      end else begin
         lineBad <= lineBadNext;
         if (lineRise && lineBadNext && underrunCount != '1)
            underrunCount <= underrunCount + 1'b1;
      end
   end

   // Line completion report back to the filler.
   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         lineDone     <= 1'b0;
         lineDoneBank <= 1'b0;
      end else begin
         lineDone <= lineFall;
         if (lineFall) lineDoneBank <= readBank;
      end
   end

   // Colour stage: expand the byte returned for last cycle's address.
   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         rgbReg <= '0;
      end else begin
         rgbReg <= expand_rgb332(ramData);
      end
   end

`ifdef LINE_PIXEL_DOUBLE_EN
   logic unusedColLsb;
   assign unusedColLsb = column[0];
   assign ramAddress   = {readBank, 1'b0, column[COL_BITS-1:1]};
`else
   assign ramAddress = {readBank, column};
`endif

   assign pipeIn = {activeIn, hsyncIn, vsyncIn, lineBadNext};

   hdmi_sync_delay #(
      .N (2),
      .W (4)
   ) u_sync_delay (
      .clock  (clock),
      .nReset (nReset),
      .din    (pipeIn),
      .dout   (pipeOut)
   );

   assign activeOut = pipeOut[3];
   assign hsyncOut  = pipeOut[2];
   assign vsyncOut  = pipeOut[1];
   assign rgbOut    = (pipeOut[3] && !pipeOut[0]) ? rgbReg : '0;

endmodule

// File: tb/tb_hdmi_line_reader.sv
// tb_hdmi_line_reader: directed checks of scan-out, underrun, bank
// handover, frame restart and mid-line reset for hdmi_line_reader.
module tb_hdmi_line_reader;

   logic        clock;
   logic        nReset;
   logic        activeIn;
   logic        hsyncIn;
   logic        vsyncIn;
   logic        bankFilled;
   logic        bankFilledId;
   logic [11:0] ramAddress;
   logic [7:0]  ramData;
   logic [23:0] rgbOut;
   logic        activeOut;
   logic        hsyncOut;
   logic        vsyncOut;
   logic        lineDone;
   logic        lineDoneBank;
   logic [7:0]  underrunCount;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   logic [13:0] hpat = 14'b00000100100011;
   logic [13:0] vpat = 14'b00000000111100;

   hdmi_line_reader #(
      .H_ACTIVE       (1280),
      .UNDERRUN_CNT_W (8)
   ) dut (
      .clock         (clock),
      .nReset        (nReset),
      .activeIn      (activeIn),
      .hsyncIn       (hsyncIn),
      .vsyncIn       (vsyncIn),
      .bankFilled    (bankFilled),
      .bankFilledId  (bankFilledId),
      .ramAddress    (ramAddress),
      .ramData       (ramData),
      .rgbOut        (rgbOut),
      .activeOut     (activeOut),
      .hsyncOut      (hsyncOut),
      .vsyncOut      (vsyncOut),
      .lineDone      (lineDone),
      .lineDoneBank  (lineDoneBank),
      .underrunCount (underrunCount)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // RAM model: each byte holds the low 8 bits of its address.
   initial ramData = 8'h00;
   always @(posedge clock) ramData <= ramAddress[7:0];

   function automatic logic [23:0] exp_rgb(input logic [7:0] d);
      int r;
      int g;
      int b;
      r = int'(d[7:5]);
      g = int'(d[4:2]);
      b = int'(d[1:0]);
      return {8'((r * 255 + 3) / 7), 8'((g * 255 + 3) / 7), 8'(b * 85)};
   endfunction

   function automatic logic [11:0] addr_of(input logic [11:0] base,
                                           input int c);
`ifdef LINE_PIXEL_DOUBLE_EN
      return base | 12'(c / 2);
`else
      return base | 12'(c);
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      activeIn = 1'b0;
      repeat (n) step();
   endtask

   task automatic fill(input logic id);
      bankFilled   = 1'b1;
      bankFilledId = id;
      step();
      bankFilled   = 1'b0;
   endtask

   task automatic run_line(input int len, input logic [11:0] base,
                           input bit good, input bit fillAtFall,
                           input bit chk);
      logic [11:0] a;
      logic [23:0] e;
      for (int c = 0; c < len + 2; c++) begin
         activeIn     = (c < len);
         bankFilled   = fillAtFall && (c == len);
         bankFilledId = 1'b0;
         if (chk) begin
            if (c < len)
               check("addr", 32'(ramAddress), 32'(addr_of(base, c)));
            if (c >= 2) begin
               a = addr_of(base, c - 2);
               e = good ? exp_rgb(a[7:0]) : 24'h0;
               check("rgb", 32'(rgbOut), 32'(e));
               check("activeOut", 32'(activeOut), 32'd1);
               if (good && a[7:0] == 8'hE0)
                  check("rgbE0", 32'(rgbOut), 32'hFF0000);
            end
            if (c == len) check("doneEarly", 32'(lineDone), 32'd0);
            if (c == len + 1) begin
               check("lineDone", 32'(lineDone), 32'd1);
               check("doneBank", 32'(lineDoneBank), 32'(base[11]));
               check("nextBase", 32'(ramAddress), 32'(base ^ 12'h800));
            end
         end
         step();
      end
      bankFilled = 1'b0;
      if (chk) begin
         check("doneEnd", 32'(lineDone), 32'd0);
         check("activeEnd", 32'(activeOut), 32'd0);
         check("rgbEnd", 32'(rgbOut), 32'd0);
      end
   endtask

   initial begin
      nReset       = 1'b0;
      activeIn     = 1'b0;
      hsyncIn      = 1'b0;
      vsyncIn      = 1'b0;
      bankFilled   = 1'b0;
      bankFilledId = 1'b0;
      repeat (3) step();

      check("rstRgb", 32'(rgbOut), 32'd0);
      check("rstAct", 32'(activeOut), 32'd0);
      check("rstHs", 32'(hsyncOut), 32'd0);
      check("rstVs", 32'(vsyncOut), 32'd0);
      check("rstDone", 32'(lineDone), 32'd0);
      check("rstDoneBank", 32'(lineDoneBank), 32'd0);
      check("rstUnder", 32'(underrunCount), 32'd0);
      check("rstAddr", 32'(ramAddress), 32'd0);
      nReset = 1'b1;
      idle(2);

      // Basic filled line on bank 0.
      fill(1'b0);
      idle(3);
      run_line(1280, 12'h000, 1'b1, 1'b0, 1'b1);
      check("underAfterGood", 32'(underrunCount), 32'd0);

      // Bank 1 never filled: blank line and one underrun.
      idle(3);
      run_line(64, 12'h800, 1'b0, 1'b0, 1'b1);
      check("under1", 32'(underrunCount), 32'd1);

      // Fill lands on the same cycle bank 0 is released.
      fill(1'b0);
      idle(2);
      run_line(8, 12'h000, 1'b1, 1'b1, 1'b1);
      fill(1'b1);
      idle(2);
      run_line(8, 12'h800, 1'b1, 1'b0, 1'b1);
      idle(2);
      run_line(8, 12'h000, 1'b1, 1'b0, 1'b1);
      check("underSetWins", 32'(underrunCount), 32'd1);

      // Frame restart with bank 1 selected.
      idle(2);
      check("preFrameAddr", 32'(ramAddress), 32'h800);
      fill(1'b0);
      for (int c = 0; c < 14; c++) begin
         hsyncIn = hpat[c];
         vsyncIn = vpat[c];
         if (c >= 2) begin
            check("hsyncDly", 32'(hsyncOut), 32'(hpat[c-2]));
            check("vsyncDly", 32'(vsyncOut), 32'(vpat[c-2]));
         end
         step();
      end
      hsyncIn = 1'b0;
      vsyncIn = 1'b0;
      check("frameAddr", 32'(ramAddress), 32'h000);
      run_line(8, 12'h000, 1'b1, 1'b0, 1'b1);

      // Underrun counter saturation.
      for (int n = 0; n < 300; n++) begin
         run_line(4, 12'h000, 1'b0, 1'b0, 1'b0);
         idle(1);
      end
      check("underSat", 32'(underrunCount), 32'd255);

      // Reset in the middle of a line.
      idle(2);
      activeIn = 1'b1;
      repeat (600) step();
      check("midCol", 32'(ramAddress & 12'h7FF), 32'(addr_of(12'h000, 600)));
      nReset = 1'b0;
      #1;
      check("midRgb", 32'(rgbOut), 32'd0);
      check("midAct", 32'(activeOut), 32'd0);
      check("midHs", 32'(hsyncOut), 32'd0);
      check("midVs", 32'(vsyncOut), 32'd0);
      check("midDone", 32'(lineDone), 32'd0);
      check("midDoneBank", 32'(lineDoneBank), 32'd0);
      check("midUnder", 32'(underrunCount), 32'd0);
      check("midAddr", 32'(ramAddress), 32'd0);
      activeIn = 1'b0;
      step();
      nReset = 1'b1;
      idle(2);
      run_line(16, 12'h000, 1'b0, 1'b0, 1'b1);
      check("underPostRst", 32'(underrunCount), 32'd1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
